// File: rtl/czonotope_serializer_if.sv
// Parallel view of a constrained zonotope: center c, generators G, constraints A*xi = b.
// Producers drive it; the serializer reads it through the reader modport.
interface CZonotope #(
    parameter int NMAX       = 3,
    parameter int NGMAX      = 15,
    parameter int NCMAX      = 12,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];
    logic [7:0]            n;
    logic [7:0]            ng;
    logic [7:0]            nc;

    modport reader (input c, G, A, b, n, ng, nc);
endinterface

// File: rtl/czonotope_serializer.sv
// Walks a CZonotope and emits it as a framed valid/ready word stream:
// header, c, G (row-major), A (row-major), b. Empty sections are skipped.
module czonotope_serializer #(
    parameter int NMAX       = 3,
    parameter int NGMAX      = 15,
    parameter int NCMAX      = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    CZonotope.reader              Z,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [2:0]            m_field_o,
    output logic                  m_last_o
);
    localparam int CI = (NMAX  > 1) ? $clog2(NMAX)  : 1;
    localparam int GI = (NGMAX > 1) ? $clog2(NGMAX) : 1;
    localparam int KI = (NCMAX > 1) ? $clog2(NCMAX) : 1;

    localparam logic [7:0] NMAX_L  = 8'(NMAX);
    localparam logic [7:0] NGMAX_L = 8'(NGMAX);
    localparam logic [7:0] NCMAX_L = 8'(NCMAX);

    localparam logic [2:0] F_HDR = 3'd0;
    localparam logic [2:0] F_C   = 3'd1;
    localparam logic [2:0] F_G   = 3'd2;
    localparam logic [2:0] F_A   = 3'd3;
    localparam logic [2:0] F_B   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_C, S_G, S_A, S_B, S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [7:0]            n_reg, n_next;
    logic [7:0]            ng_reg, ng_next;
    logic [7:0]            nc_reg, nc_next;
    logic [7:0]            i_reg, i_next;
    logic [7:0]            j_reg, j_next;
    logic [15:0]           rem_reg, rem_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic                  valid_reg, valid_next;
    logic                  last_reg, last_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [2:0]            field_reg, field_next;

    logic                  accept;
    logic                  launch;
    logic                  adv;
    logic                  dims_bad;
    logic [15:0]           total;

    // First non-empty section strictly after 'from' in frame order.
    function automatic state_t next_section(input state_t from, input logic [7:0] n,
                                            input logic [7:0] ng, input logic [7:0] nc);
        state_t s;
        s = S_DONE;
        if ((nc != 8'd0) && (from inside {S_HDR, S_C, S_G, S_A}))
            s = S_B;
        if ((nc != 8'd0) && (ng != 8'd0) && (from inside {S_HDR, S_C, S_G}))
            s = S_A;
        if ((n != 8'd0) && (ng != 8'd0) && (from inside {S_HDR, S_C}))
            s = S_G;
        if ((n != 8'd0) && (from == S_HDR))
            s = S_C;
        return s;
    endfunction

    assign accept   = valid_reg & m_ready_i;
    assign dims_bad = (Z.n > NMAX_L) | (Z.ng > NGMAX_L) | (Z.nc > NCMAX_L);
    assign total    = 16'd1 + 16'(Z.n) + 16'(Z.n) * 16'(Z.ng)
                    + 16'(Z.nc) * 16'(Z.ng) + 16'(Z.nc);

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        ng_next    = ng_reg;
        nc_next    = nc_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        rem_next   = rem_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        valid_next = valid_reg;
        last_next  = last_reg;
        data_next  = data_reg;
        field_next = field_reg;
        launch     = 1'b0;
        adv        = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    if (dims_bad) begin
                        err_next = 1'b1;
                    end else begin
                        launch     = 1'b1;
                        state_next = S_HDR;
                        n_next     = Z.n;
                        ng_next    = Z.ng;
                        nc_next    = Z.nc;
                        i_next     = 8'd0;
                        j_next     = 8'd0;
                    end
                end
            end
            S_HDR: begin
                if (accept) begin
                    adv        = 1'b1;
                    state_next = next_section(S_HDR, n_reg, ng_reg, nc_reg);
                    i_next     = 8'd0;
                    j_next     = 8'd0;
                end
            end
            S_C: begin
                if (accept) begin
                    adv = 1'b1;
                    if (i_reg == n_reg - 8'd1) begin
                        state_next = next_section(S_C, n_reg, ng_reg, nc_reg);
                        i_next     = 8'd0;
                    end else begin
                        i_next = i_reg + 8'd1;
                    end
                end
            end
            S_G: begin
                if (accept) begin
                    adv = 1'b1;
                    if (j_reg == ng_reg - 8'd1) begin
                        j_next = 8'd0;
                        if (i_reg == n_reg - 8'd1) begin
                            state_next = next_section(S_G, n_reg, ng_reg, nc_reg);
                            i_next     = 8'd0;
                        end else begin
                            i_next = i_reg + 8'd1;
                        end
                    end else begin
                        j_next = j_reg + 8'd1;
                    end
                end
            end
            S_A: begin
                if (accept) begin
                    adv = 1'b1;
                    if (j_reg == ng_reg - 8'd1) begin
                        j_next = 8'd0;
                        if (i_reg == nc_reg - 8'd1) begin
                            state_next = next_section(S_A, n_reg, ng_reg, nc_reg);
                            i_next     = 8'd0;
                        end else begin
                            i_next = i_reg + 8'd1;
                        end
                    end else begin
                        j_next = j_reg + 8'd1;
                    end
                end
            end
            S_B: begin
                if (accept) begin
                    adv = 1'b1;
                    if (i_reg == nc_reg - 8'd1) begin
                        state_next = S_DONE;
                        i_next     = 8'd0;
                    end else begin
                        i_next = i_reg + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (launch) begin
            busy_next  = 1'b1;
            valid_next = 1'b1;
            field_next = F_HDR;
            data_next  = DATA_WIDTH'({8'd0, Z.nc, Z.ng, Z.n});
            rem_next   = total;
            last_next  = (total == 16'd1);
        end

        // Preload the beat for the new position so outputs stay registered.
        if (adv) begin
            rem_next = rem_reg - 16'd1;
            if (state_next == S_DONE) begin
                busy_next  = 1'b0;
                done_next  = 1'b1;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end else begin
                valid_next = 1'b1;
                last_next  = (rem_next == 16'd1);
                unique case (state_next)
                    S_C: begin
                        field_next = F_C;
                        data_next  = Z.c[i_next[CI-1:0]];
                    end
                    S_G: begin
                        field_next = F_G;
                        data_next  = Z.G[i_next[CI-1:0]][j_next[GI-1:0]];
                    end
                    S_A: begin
                        field_next = F_A;
                        data_next  = Z.A[i_next[KI-1:0]][j_next[GI-1:0]];
                    end
                    S_B: begin
                        field_next = F_B;
                        data_next  = Z.b[i_next[KI-1:0]];
                    end
                    default: begin
                        field_next = field_reg;
                        data_next  = data_reg;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= S_IDLE;
            n_reg     <= 8'd0;
            ng_reg    <= 8'd0;
            nc_reg    <= 8'd0;
            i_reg     <= 8'd0;
            j_reg     <= 8'd0;
            rem_reg   <= 16'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            data_reg  <= '0;
            field_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            ng_reg    <= ng_next;
            nc_reg    <= nc_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            rem_reg   <= rem_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            data_reg  <= data_next;
            field_reg <= field_next;
        end
    end

    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign err_o     = err_reg;
    assign m_valid_o = valid_reg;
    assign m_last_o  = last_reg;
    assign m_data_o  = data_reg;
    assign m_field_o = field_reg;

endmodule

// File: tb/tb_czonotope_serializer.sv
// Directed-plus-random bench: each frame is compared beat by beat against an
// expected stream built from the frame layout with plain nested loops.
module tb_czonotope_serializer;
    localparam int NMAX  = 3;
    localparam int NGMAX = 15;
    localparam int NCMAX = 12;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, done, err, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic [2:0]    m_field;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    CZonotope #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW)) z ();

    czonotope_serializer #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .start_i  (start),
        .Z        (z),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_data_o (m_data),
        .m_field_o(m_field),
        .m_last_o (m_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n, input int ng, input int nc);
        z.n  = 8'(n);
        z.ng = 8'(ng);
        z.nc = 8'(nc);
        for (int i = 0; i < NMAX; i++) begin
            z.c[i] = $urandom();
            for (int j = 0; j < NGMAX; j++) z.G[i][j] = $urandom();
        end
        for (int k = 0; k < NCMAX; k++) begin
            z.b[k] = $urandom();
            for (int j = 0; j < NGMAX; j++) z.A[k][j] = $urandom();
        end
    endtask

    // Expected stream entry: {last, field, data}.
    task automatic run_frame(input int n, input int ng, input int nc, input bit rnd_ready,
                             input bit restart, input bit perturb);
        logic [35:0] exp_q[$];
        logic [35:0] beat, held;
        logic [31:0] hdr;
        bit          have_held, finished, restarted;
        int          idx, dones, size;

        fill(n, ng, nc);
        hdr = {8'd0, 8'(nc), 8'(ng), 8'(n)};
        exp_q.push_back({1'b0, 3'd0, hdr});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 3'd1, z.c[i]});
        for (int i = 0; i < n; i++)
            for (int j = 0; j < ng; j++) exp_q.push_back({1'b0, 3'd2, z.G[i][j]});
        for (int k = 0; k < nc; k++)
            for (int j = 0; j < ng; j++) exp_q.push_back({1'b0, 3'd3, z.A[k][j]});
        for (int k = 0; k < nc; k++) exp_q.push_back({1'b0, 3'd4, z.b[k]});
        size = exp_q.size();
        exp_q[size-1][35] = 1'b1;

        @(negedge clk);
        m_ready = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_valid", 64'(m_valid), 64'd1);
        check("busy_on", 64'(busy), 64'd1);

        idx = 0; have_held = 0; finished = 0; restarted = 0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            beat = {m_last, m_field, m_data};
            if (have_held && m_valid) check("stall_hold", 64'(beat), 64'(held));
            if (restart && idx == 3 && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            if (perturb && idx == 5) begin
                z.n  = 8'd1;
                z.ng = 8'd1;
                z.nc = 8'd0;
            end
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                if (idx < size) check($sformatf("beat%0d", idx), 64'(beat), 64'(exp_q[idx]));
                else            check("extra_beat", 64'(idx), 64'(size));
                $display("[TB] n=%0d ng=%0d nc=%0d beat %0d field=%0d data=%08h last=%0d",
                         n, ng, nc, idx, m_field, m_data, m_last);
                idx++;
                if (m_last) finished = 1;
                have_held = 0;
            end else begin
                have_held = m_valid;
                held = beat;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("beat_count", 64'(idx), 64'(size));
        check("done_pulse", 64'(done), 64'd1);
        check("busy_off", 64'(busy), 64'd0);
        check("valid_off", 64'(m_valid), 64'd0);
        dones = done ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("done_count", 64'(dones), 64'd1);
        check("idle_valid", 64'(m_valid), 64'd0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, err, m_valid, m_last, m_field, m_data}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_frame(2, 3, 1, 0, 0, 0);
        run_frame(2, 3, 1, 1, 0, 1);
        run_frame(3, 2, 0, 1, 0, 0);

        // Oversized dimensions are rejected with a single err pulse.
        fill(4, 1, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("err_pulse_n", 64'(err), 64'd1);
        check("err_valid", 64'(m_valid), 64'd0);
        check("err_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("err_clear", 64'(err), 64'd0);
        check("err_valid2", 64'(m_valid), 64'd0);
        fill(1, 16, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("err_pulse_ng", 64'(err), 64'd1);
        @(negedge clk);

        // Reset asserted while beat 5 is on the bus drops the frame.
        fill(2, 3, 1);
        m_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", 64'(m_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_no_done", 64'(done), 64'd0);
        run_frame(2, 3, 1, 0, 1, 0);

        run_frame(3, 15, 12, 1, 0, 0);
        run_frame(1, 0, 3, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
